// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR slice: CSR addresses,
// mstatus bit positions and the single implemented mie/mip field.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MTIME    = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMP = 12'h7C8;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // mstatus bit indices
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // MTIE in mie and MTIP in mip share this position
  localparam int MIX_MT = 7;

endpackage

// File: rtl/csr_counter64.sv
// Free-running counter with a synchronous load port.
// A load takes priority over the increment in the same cycle; the count
// wraps silently at all-ones.
module csr_counter64 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count register: load beats increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR register file: mstatus, mie, mtvec, mscratch, mepc,
// mcause, mip and the 64-bit mcycle/minstret counters. Reads are
// combinational with a bypass of the same-cycle EX write; trap-entry writes
// from the trap controller override EX writes on mepc/mcause/mstatus.
// Optional feature macro: CSR_TIMER_EN adds mtime/mtimecmp, drives mip.MTIP
// and a registered timer interrupt request.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_we_i,
  input  logic            trap_we_i,
  input  logic [XLEN-1:0] trap_mepc_i,
  input  logic [XLEN-1:0] trap_mcause_i,
  input  logic [XLEN-1:0] trap_mstatus_i,
  input  logic            instr_retire_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            timer_irq_o
);

  logic [XLEN-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic            mie_mtie_q;
  logic [XLEN-1:0] mcycle, minstret;
  logic            mtip;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic wr_mcycle, wr_minstret, wr_mtime, wr_mtimecmp;
  logic wr_valid;
  logic [XLEN-1:0] rd_val;

  // decode the EX write into per-CSR strobes; mip and unmapped addresses never strobe
  always_comb begin
    wr_mstatus  = 1'b0;
    wr_mie      = 1'b0;
    wr_mtvec    = 1'b0;
    wr_mscratch = 1'b0;
    wr_mepc     = 1'b0;
    wr_mcause   = 1'b0;
    wr_mcycle   = 1'b0;
    wr_minstret = 1'b0;
    wr_mtime    = 1'b0;
    wr_mtimecmp = 1'b0;
    if (csr_we_i) begin
      case (csr_waddr_i)
        CSR_MSTATUS:  wr_mstatus  = 1'b1;
        CSR_MIE:      wr_mie      = 1'b1;
        CSR_MTVEC:    wr_mtvec    = 1'b1;
        CSR_MSCRATCH: wr_mscratch = 1'b1;
        CSR_MEPC:     wr_mepc     = 1'b1;
        CSR_MCAUSE:   wr_mcause   = 1'b1;
        CSR_MCYCLE:   wr_mcycle   = 1'b1;
        CSR_MINSTRET: wr_minstret = 1'b1;
`ifdef CSR_TIMER_EN
        CSR_MTIME:    wr_mtime    = 1'b1;
        CSR_MTIMECMP: wr_mtimecmp = 1'b1;
`endif
        default: ;
      endcase
    end
    wr_valid = wr_mstatus | wr_mie | wr_mtvec | wr_mscratch | wr_mepc |
               wr_mcause | wr_mcycle | wr_minstret | wr_mtime | wr_mtimecmp;
  end

  // trap-entry CSRs: a trap write overrides an EX write to the same CSR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else if (trap_we_i) begin
      mstatus_q <= trap_mstatus_i;
      mepc_q    <= trap_mepc_i;
      mcause_q  <= trap_mcause_i;
    end else begin
      if (wr_mstatus) mstatus_q <= csr_wdata_i;
      if (wr_mepc)    mepc_q    <= csr_wdata_i;
      if (wr_mcause)  mcause_q  <= csr_wdata_i;
    end
  end

  // EX-only CSRs, unaffected by trap writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mie_mtie_q <= 1'b0;
    end else begin
      if (wr_mtvec)    mtvec_q    <= csr_wdata_i;
      if (wr_mscratch) mscratch_q <= csr_wdata_i;
      if (wr_mie)      mie_mtie_q <= csr_wdata_i[MIX_MT];
    end
  end

  csr_counter64 #(.W(XLEN)) u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_mcycle),
    .load_val (csr_wdata_i),
    .inc      (1'b1),
    .count    (mcycle)
  );

  csr_counter64 #(.W(XLEN)) u_minstret (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_minstret),
    .load_val (csr_wdata_i),
    .inc      (instr_retire_i),
    .count    (minstret)
  );

`ifdef CSR_TIMER_EN
  logic [XLEN-1:0] mtime, mtimecmp_q;
  logic            timer_irq_q;

  csr_counter64 #(.W(XLEN)) u_mtime (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_mtime),
    .load_val (csr_wdata_i),
    .inc      (1'b1),
    .count    (mtime)
  );

  assign mtip = (mtime >= mtimecmp_q);

  // mtimecmp resets to all-ones so no interrupt is pending out of reset;
  // the interrupt request is registered from the gated pending bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp_q  <= '1;
      timer_irq_q <= 1'b0;
    end else begin
      if (wr_mtimecmp) mtimecmp_q <= csr_wdata_i;
      timer_irq_q <= mtip & mie_mtie_q & mstatus_q[MSTATUS_MIE];
    end
  end

  assign timer_irq_o = timer_irq_q;
`else
  assign mtip        = 1'b0;
  assign timer_irq_o = 1'b0;
`endif

  // read mux with bypass of a same-cycle EX write to a writable CSR
  always_comb begin
    rd_val = '0;
    case (csr_raddr_i)
      CSR_MSTATUS:  rd_val = mstatus_q;
      CSR_MIE:      rd_val = XLEN'(mie_mtie_q) << MIX_MT;
      CSR_MTVEC:    rd_val = mtvec_q;
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_MCAUSE:   rd_val = mcause_q;
      CSR_MIP:      rd_val = XLEN'(mtip) << MIX_MT;
      CSR_MCYCLE:   rd_val = mcycle;
      CSR_MINSTRET: rd_val = minstret;
`ifdef CSR_TIMER_EN
      CSR_MTIME:    rd_val = mtime;
      CSR_MTIMECMP: rd_val = mtimecmp_q;
`endif
      default:      rd_val = '0;
    endcase
    if (wr_valid && (csr_waddr_i == csr_raddr_i)) begin
      rd_val = csr_wdata_i;
    end
  end

  assign csr_rdata_o = rd_val;
  assign mtvec_o     = mtvec_q;
  assign mstatus_o   = mstatus_q;
  assign mepc_o      = mepc_q;

endmodule
